dispatch: RTL and testbench
===========================

Name: dispatch

Overview:
- Stage directly downstream of register renaming.
- Takes one renamed bundle of up to RENAME_WIDTH micro-ops, allocates consecutive ROB entries, and routes each uop to the integer or memory issue queue.
- Stalls the rename stage when ROB or issue-queue capacity is insufficient, using internal occupancy and credit counters.
- Bundles are dispatched all-or-nothing.

Parameters:
- RENAME_WIDTH, `RENAME_WIDTH (4): lanes per bundle.
- ROB_SIZE, 64: ROB entries; must be a power of two.
- ROB_INDEX_SIZE, 6: log2(ROB_SIZE).
- IQ_INT_SIZE, 16: integer issue-queue entries.
- IQ_MEM_SIZE, 16: memory issue-queue entries.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_valid  in  1  renamed bundle present.
- lane_valid  in  RENAME_WIDTH  per-lane valid; valid lanes are packed from lane 0.
- uop_in  in  micro_op_t[RENAME_WIDTH]  renamed uops.
- ready  out  1  bundle accepted this cycle when input_valid & ready.
- recover  in  1  mispredict flush.
- recover_rob_tail  in  ROB_INDEX_SIZE  ROB tail after flush.
- recover_rob_count  in  ROB_INDEX_SIZE+1  ROB occupancy after flush.
- rob_retire_count  in  $clog2(RENAME_WIDTH+1)  ROB entries freed this cycle.
- iq_int_issue_count  in  $clog2(RENAME_WIDTH+1)  int IQ entries freed this cycle.
- iq_mem_issue_count  in  $clog2(RENAME_WIDTH+1)  mem IQ entries freed this cycle.
- uop_out  out  micro_op_t[RENAME_WIDTH]  uops with rob_index filled in.
- rob_alloc_valid  out  RENAME_WIDTH  write lane into ROB.
- iq_int_valid  out  RENAME_WIDTH  write lane into int IQ.
- iq_mem_valid  out  RENAME_WIDTH  write lane into mem IQ.

Behaviour:
- Reset (reset==0, asynchronous):
  - hold_valid=0, rob_tail=0, rob_count=0.
  - int_credit=IQ_INT_SIZE, mem_credit=IQ_MEM_SIZE.
  - All *_valid outputs 0; uop_out=0.
- Hold register:
  - Accept when input_valid & ready; latch uop_in and lane_valid into the hold register, hold_valid<=1.
  - ready = ~recover & (~hold_valid | fire). Combinational; no dependency on input_valid.
- Fire condition: hold_valid & ~recover & n_all<=ROB_SIZE-rob_count & n_int<=int_credit & n_mem<=mem_credit.
  - n_all = popcount of held lane_valid.
  - n_int = lanes with fu_code in {FU_ALU, FU_BR, FU_MUL, FU_DIV}.
  - n_mem = lanes with fu_code==FU_LSU.
  - Credit checks use registered counters only; frees arriving in the same cycle count from the next cycle.
- On fire, outputs are registered at that edge and valid for exactly one cycle:
  - uop_out[i].rob_index = (rob_tail+k) mod ROB_SIZE, where k is the lane rank; tail wraps naturally.
  - rob_alloc_valid / iq_int_valid / iq_mem_valid are set per lane.
  - Invalid lanes have all valids 0.
  - If no new bundle is accepted, hold_valid<=0.
- No fire: all output valids deasserted next cycle; the held bundle persists unchanged.
- Latency: accepted at edge N; outputs earliest after edge N+1; throughput one bundle/cycle.
- Counter update each cycle:
  - rob_count += fired n_all - rob_retire_count.
  - int_credit += iq_int_issue_count - fired n_int.
  - mem_credit += iq_mem_issue_count - fired n_mem.
  - rob_tail += fired n_all.
- Recover has highest priority:
  - hold_valid<=0; outputs invalid next cycle.
  - rob_tail<=recover_rob_tail; rob_count<=recover_rob_count.
  - Credits restored to full (IQs flush on recover); retire/issue counts in that cycle are ignored.
- Empty bundle (lane_valid==0) is accepted and dispatches nothing; counters unchanged.
- Retire count greater than rob_count, or credit above queue size, is illegal; guard with assertions.

Decomposition:
- Shared package (micro_op.svh):
  - rob_index field in micro_op_t.
  - fu_code_t enum (FU_ALU, FU_BR, FU_MUL, FU_DIV, FU_LSU).
  - `ROB_SIZE, `ROB_INDEX_SIZE, `IQ_INT_SIZE, `IQ_MEM_SIZE.
- One sub-module, dispatch_count: combinational popcount/rank producing n_all, n_int, n_mem and per-lane rank k.

Test Plan:
- Basic allocation: after reset, 4 valid ALU lanes -> next cycle rob_index 0,1,2,3; iq_int_valid=4'b1111; rob_count=4; int_credit=12.
- ROB wrap: rob_tail=62, rob_count=10, 3 valid lanes -> rob_index 62,63,0; rob_tail=1.
- ROB stall: rob_count=62, 4 lanes -> no fire, ready=0. Then rob_retire_count=2 -> fires the following cycle.
- Mem credit stall: mem_credit=1, bundle with 2 FU_LSU lanes -> stall; iq_mem_issue_count=1 -> fires next cycle with iq_mem_valid on both lanes.
- Recover with held bundle: recover=1, recover_rob_tail=20, recover_rob_count=5 -> no output next cycle; hold cleared; the next bundle gets rob_index 20.
- Mid-operation reset: reset low while hold_valid=1 -> all valids 0 immediately, without waiting for a clock edge; counters at reset values.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and sizing for the dispatch stage: micro-op layout,
// functional-unit codes and the ROB / issue-queue dimensions.
package dispatch_pkg;

    // Bundle width and back-end capacities.
    localparam int RENAME_WIDTH   = 4;
    localparam int ROB_SIZE       = 64;
    localparam int ROB_INDEX_SIZE = 6;
    localparam int IQ_INT_SIZE    = 16;
    localparam int IQ_MEM_SIZE    = 16;

    // Derived widths.
    localparam int CNT_W     = $clog2(RENAME_WIDTH + 1);   // lane counts 0..RENAME_WIDTH
    localparam int ROB_CNT_W = ROB_INDEX_SIZE + 1;         // ROB occupancy 0..ROB_SIZE
    localparam int INT_CR_W  = $clog2(IQ_INT_SIZE + 1);    // int credits 0..IQ_INT_SIZE
    localparam int MEM_CR_W  = $clog2(IQ_MEM_SIZE + 1);    // mem credits 0..IQ_MEM_SIZE

    // Functional unit a uop is steered to.
    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_BR  = 3'd1,
        FU_MUL = 3'd2,
        FU_DIV = 3'd3,
        FU_LSU = 3'd4
    } fu_code_t;

    // Renamed micro-op; rob_index is filled in by dispatch.
    typedef struct packed {
        logic [31:0]               pc;
        fu_code_t                  fu_code;
        logic [6:0]                prd;
        logic [6:0]                prs1;
        logic [6:0]                prs2;
        logic [ROB_INDEX_SIZE-1:0] rob_index;
    } micro_op_t;

    // Uops executed by the integer issue queue.
    function automatic logic is_int_fu(input fu_code_t fu);
        return (fu == FU_ALU) || (fu == FU_BR) || (fu == FU_MUL) || (fu == FU_DIV);
    endfunction

endpackage

// File: rtl/dispatch_count.sv
// Combinational lane census for a held bundle: total/int/mem lane counts,
// the rank of each lane among the valid lanes, and per-lane queue steering.
module dispatch_count
    import dispatch_pkg::*;
(
    input  logic      [RENAME_WIDTH-1:0]            lane_valid_i,
    input  micro_op_t [RENAME_WIDTH-1:0]            uops_i,
    output logic      [CNT_W-1:0]                   n_all_o,
    output logic      [CNT_W-1:0]                   n_int_o,
    output logic      [CNT_W-1:0]                   n_mem_o,
    output logic      [RENAME_WIDTH-1:0][CNT_W-1:0] rank_o,
    output logic      [RENAME_WIDTH-1:0]            lane_int_o,
    output logic      [RENAME_WIDTH-1:0]            lane_mem_o
);

    // Running popcount: each lane's rank is the number of valid lanes before it.
    always_comb begin
        n_all_o    = '0;
        n_int_o    = '0;
        n_mem_o    = '0;
        rank_o     = '0;
        lane_int_o = '0;
        lane_mem_o = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rank_o[i] = n_all_o;
            if (lane_valid_i[i]) begin
                n_all_o = n_all_o + CNT_W'(1);
                if (is_int_fu(uops_i[i].fu_code)) begin
                    lane_int_o[i] = 1'b1;
                    n_int_o       = n_int_o + CNT_W'(1);
                end
                if (uops_i[i].fu_code == FU_LSU) begin
                    lane_mem_o[i] = 1'b1;
                    n_mem_o       = n_mem_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: holds one renamed bundle, allocates consecutive ROB
// entries and steers each uop to the integer or memory issue queue.
// A bundle dispatches all-or-nothing once the ROB and both queues have room.
//
// Handshake: the bundle on uop_in/lane_valid transfers on a rising edge
// where input_valid & ready. ready is combinational, never looks at
// input_valid, and is high when the hold register is empty or is being
// drained this cycle, and no recover is in progress.
module dispatch
    import dispatch_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             input_valid,
    input  logic      [RENAME_WIDTH-1:0]     lane_valid,
    input  micro_op_t [RENAME_WIDTH-1:0]     uop_in,
    output logic                             ready,
    input  logic                             recover,
    input  logic      [ROB_INDEX_SIZE-1:0]   recover_rob_tail,
    input  logic      [ROB_CNT_W-1:0]        recover_rob_count,
    input  logic      [CNT_W-1:0]            rob_retire_count,
    input  logic      [CNT_W-1:0]            iq_int_issue_count,
    input  logic      [CNT_W-1:0]            iq_mem_issue_count,
    output micro_op_t [RENAME_WIDTH-1:0]     uop_out,
    output logic      [RENAME_WIDTH-1:0]     rob_alloc_valid,
    output logic      [RENAME_WIDTH-1:0]     iq_int_valid,
    output logic      [RENAME_WIDTH-1:0]     iq_mem_valid
);

    // Hold register.
    logic                                hold_valid_q, hold_valid_d;
    logic      [RENAME_WIDTH-1:0]        hold_lanes_q, hold_lanes_d;
    micro_op_t [RENAME_WIDTH-1:0]        hold_uops_q,  hold_uops_d;

    // Occupancy and credit tracking.
    logic      [ROB_INDEX_SIZE-1:0]      rob_tail_q,   rob_tail_d;
    logic      [ROB_CNT_W-1:0]           rob_count_q,  rob_count_d;
    logic      [INT_CR_W-1:0]            int_credit_q, int_credit_d;
    logic      [MEM_CR_W-1:0]            mem_credit_q, mem_credit_d;

    // Registered outputs.
    micro_op_t [RENAME_WIDTH-1:0]        uop_out_q,   uop_out_d;
    logic      [RENAME_WIDTH-1:0]        alloc_q,     alloc_d;
    logic      [RENAME_WIDTH-1:0]        int_vld_q,   int_vld_d;
    logic      [RENAME_WIDTH-1:0]        mem_vld_q,   mem_vld_d;

    // Census of the held bundle.
    logic      [CNT_W-1:0]               n_all, n_int, n_mem;
    logic      [RENAME_WIDTH-1:0][CNT_W-1:0] lane_rank;
    logic      [RENAME_WIDTH-1:0]        lane_int, lane_mem;

    logic                                fire;
    logic                                accept;
    logic      [ROB_CNT_W-1:0]           rob_free;
    logic      [CNT_W-1:0]               fired_all, fired_int, fired_mem;

    dispatch_count u_count (
        .lane_valid_i (hold_lanes_q),
        .uops_i       (hold_uops_q),
        .n_all_o      (n_all),
        .n_int_o      (n_int),
        .n_mem_o      (n_mem),
        .rank_o       (lane_rank),
        .lane_int_o   (lane_int),
        .lane_mem_o   (lane_mem)
    );

    // Fire / ready decision from registered occupancy and credits only.
    always_comb begin
        rob_free  = ROB_CNT_W'(ROB_SIZE) - rob_count_q;
        fire      = hold_valid_q && !recover
                    && (ROB_CNT_W'(n_all) <= rob_free)
                    && (INT_CR_W'(n_int)  <= int_credit_q)
                    && (MEM_CR_W'(n_mem)  <= mem_credit_q);
        ready     = !recover && (!hold_valid_q || fire);
        accept    = input_valid && ready;
        fired_all = fire ? n_all : '0;
        fired_int = fire ? n_int : '0;
        fired_mem = fire ? n_mem : '0;
    end

    // Hold register next state: recover flushes, accept refills, fire drains.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_lanes_d = hold_lanes_q;
        hold_uops_d  = hold_uops_q;
        if (recover) begin
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_valid_d = 1'b1;
            hold_lanes_d = lane_valid;
            hold_uops_d  = uop_in;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end
    end

    // Counter next state; recover restores the ROB pointers and full credits.
    always_comb begin
        rob_tail_d   = rob_tail_q;
        rob_count_d  = rob_count_q;
        int_credit_d = int_credit_q;
        mem_credit_d = mem_credit_q;
        if (recover) begin
            rob_tail_d   = recover_rob_tail;
            rob_count_d  = recover_rob_count;
            int_credit_d = INT_CR_W'(IQ_INT_SIZE);
            mem_credit_d = MEM_CR_W'(IQ_MEM_SIZE);
        end else begin
            rob_tail_d   = rob_tail_q + ROB_INDEX_SIZE'(fired_all);
            rob_count_d  = rob_count_q + ROB_CNT_W'(fired_all) - ROB_CNT_W'(rob_retire_count);
            int_credit_d = int_credit_q + INT_CR_W'(iq_int_issue_count) - INT_CR_W'(fired_int);
            mem_credit_d = mem_credit_q + MEM_CR_W'(iq_mem_issue_count) - MEM_CR_W'(fired_mem);
        end
    end

    // Output next state: one-cycle valid pulse per lane, ROB index by lane rank.
    always_comb begin
        uop_out_d = uop_out_q;
        alloc_d   = '0;
        int_vld_d = '0;
        mem_vld_d = '0;
        if (fire) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                uop_out_d[i]           = hold_uops_q[i];
                uop_out_d[i].rob_index = rob_tail_q + ROB_INDEX_SIZE'(lane_rank[i]);
            end
            alloc_d   = hold_lanes_q;
            int_vld_d = lane_int;
            mem_vld_d = lane_mem;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid_q <= 1'b0;
            hold_lanes_q <= '0;
            hold_uops_q  <= '0;
            rob_tail_q   <= '0;
            rob_count_q  <= '0;
            int_credit_q <= INT_CR_W'(IQ_INT_SIZE);
            mem_credit_q <= MEM_CR_W'(IQ_MEM_SIZE);
            uop_out_q    <= '0;
            alloc_q      <= '0;
            int_vld_q    <= '0;
            mem_vld_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_lanes_q <= hold_lanes_d;
            hold_uops_q  <= hold_uops_d;
            rob_tail_q   <= rob_tail_d;
            rob_count_q  <= rob_count_d;
            int_credit_q <= int_credit_d;
            mem_credit_q <= mem_credit_d;
            uop_out_q    <= uop_out_d;
            alloc_q      <= alloc_d;
            int_vld_q    <= int_vld_d;
            mem_vld_q    <= mem_vld_d;
        end
    end

    assign uop_out         = uop_out_q;
    assign rob_alloc_valid = alloc_q;
    assign iq_int_valid    = int_vld_q;
    assign iq_mem_valid    = mem_vld_q;

    // Illegal upstream behaviour: over-retiring the ROB or over-issuing a queue.
    a_retire_le_count: assert property (@(posedge clock) disable iff (!reset || recover)
        ROB_CNT_W'(rob_retire_count) <= rob_count_q);
    a_rob_count_bound: assert property (@(posedge clock) disable iff (!reset)
        rob_count_q <= ROB_CNT_W'(ROB_SIZE));
    a_int_credit_bound: assert property (@(posedge clock) disable iff (!reset || recover)
        ({1'b0, int_credit_q} + (INT_CR_W+1)'(iq_int_issue_count)) <= (INT_CR_W+1)'(IQ_INT_SIZE));
    a_mem_credit_bound: assert property (@(posedge clock) disable iff (!reset || recover)
        ({1'b0, mem_credit_q} + (MEM_CR_W+1)'(iq_mem_issue_count)) <= (MEM_CR_W+1)'(IQ_MEM_SIZE));

endmodule

// File: tb/tb_dispatch.sv
// Bench for dispatch: directed bundles with hand-computed ROB indices and
// queue steering, checked by a scoreboard that pops on every output pulse.
module tb_dispatch;
    import dispatch_pkg::*;

    localparam int EW = 12 + RENAME_WIDTH * (ROB_INDEX_SIZE + 8);

    logic                            clock;
    logic                            reset;
    logic                            input_valid;
    logic      [RENAME_WIDTH-1:0]    lane_valid;
    micro_op_t [RENAME_WIDTH-1:0]    uop_in;
    logic                            ready;
    logic                            recover;
    logic      [ROB_INDEX_SIZE-1:0]  recover_rob_tail;
    logic      [ROB_CNT_W-1:0]       recover_rob_count;
    logic      [CNT_W-1:0]           rob_retire_count;
    logic      [CNT_W-1:0]           iq_int_issue_count;
    logic      [CNT_W-1:0]           iq_mem_issue_count;
    micro_op_t [RENAME_WIDTH-1:0]    uop_out;
    logic      [RENAME_WIDTH-1:0]    rob_alloc_valid;
    logic      [RENAME_WIDTH-1:0]    iq_int_valid;
    logic      [RENAME_WIDTH-1:0]    iq_mem_valid;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    dispatch dut (
        .clock              (clock),
        .reset              (reset),
        .input_valid        (input_valid),
        .lane_valid         (lane_valid),
        .uop_in             (uop_in),
        .ready              (ready),
        .recover            (recover),
        .recover_rob_tail   (recover_rob_tail),
        .recover_rob_count  (recover_rob_count),
        .rob_retire_count   (rob_retire_count),
        .iq_int_issue_count (iq_int_issue_count),
        .iq_mem_issue_count (iq_mem_issue_count),
        .uop_out            (uop_out),
        .rob_alloc_valid    (rob_alloc_valid),
        .iq_int_valid       (iq_int_valid),
        .iq_mem_valid       (iq_mem_valid)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Expected output record: valids plus (rob_index, pc[7:0]) of each valid lane.
    function automatic logic [EW-1:0] mk_exp(input logic [3:0] a, input logic [3:0] iv,
                                             input logic [3:0] mv, input logic [5:0] i0,
                                             input logic [5:0] i1, input logic [5:0] i2,
                                             input logic [5:0] i3, input logic [7:0] pcb);
        logic [5:0]    idx[4];
        logic [EW-1:0] e;
        idx[0] = i0; idx[1] = i1; idx[2] = i2; idx[3] = i3;
        e = '0;
        e[EW-1 -: 12] = {a, iv, mv};
        for (int i = 0; i < 4; i++) begin
            if (a[i]) e[i*14 +: 14] = {idx[i], pcb + 8'(i)};
        end
        return e;
    endfunction

    // Monitor: every output pulse must match the head of the expected queue.
    initial begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clock);
            if (reset && ((|rob_alloc_valid) || (|iq_int_valid) || (|iq_mem_valid))) begin
                act = '0;
                act[EW-1 -: 12] = {rob_alloc_valid, iq_int_valid, iq_mem_valid};
                for (int i = 0; i < 4; i++) begin
                    if (rob_alloc_valid[i]) act[i*14 +: 14] = {uop_out[i].rob_index, uop_out[i].pc[7:0]};
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %h exp none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL out_bundle got %h exp %h", act, exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one bundle (pc of lane i = pcb+i) and wait, bounded, for acceptance.
    task automatic send(input logic [3:0] lv, input fu_code_t f0, input fu_code_t f1,
                        input fu_code_t f2, input fu_code_t f3, input logic [7:0] pcb);
        fu_code_t f[4];
        int n;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        for (int i = 0; i < 4; i++) begin
            uop_in[i]         = '0;
            uop_in[i].pc      = 32'(pcb) + 32'(i);
            uop_in[i].fu_code = f[i];
            uop_in[i].prd     = 7'($urandom_range(0, 127));
            uop_in[i].prs1    = 7'($urandom_range(0, 127));
            uop_in[i].prs2    = 7'($urandom_range(0, 127));
        end
        input_valid = 1'b1;
        lane_valid  = lv;
        #1;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 exp ready=1 pc=%0h", pcb);
        end
        tick();
        input_valid = 1'b0;
        lane_valid  = '0;
    endtask

    task automatic do_recover(input logic [5:0] tail, input logic [6:0] cnt);
        recover           = 1'b1;
        recover_rob_tail  = tail;
        recover_rob_count = cnt;
        #1;
        check("ready_during_recover", 64'(ready), 64'd0);
        tick();
        recover = 1'b0;
    endtask

    initial begin
        reset              = 1'b0;
        input_valid        = 1'b0;
        lane_valid         = '0;
        uop_in             = '0;
        recover            = 1'b0;
        recover_rob_tail   = '0;
        recover_rob_count  = '0;
        rob_retire_count   = '0;
        iq_int_issue_count = '0;
        iq_mem_issue_count = '0;
        repeat (3) tick();
        check("reset_alloc", 64'(rob_alloc_valid), 64'd0);
        check("reset_int", 64'(iq_int_valid), 64'd0);
        check("reset_mem", 64'(iq_mem_valid), 64'd0);
        check("reset_uop_out_zero", 64'(uop_out != '0), 64'd0);
        check("reset_ready", 64'(ready), 64'd1);
        reset = 1'b1;
        tick();

        // Basic allocation, then a mixed bundle continuing the tail, then an empty bundle.
        exp_q.push_back(mk_exp(4'b1111, 4'b1111, 4'b0000, 0, 1, 2, 3, 8'h10));
        send(4'b1111, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h10);
        exp_q.push_back(mk_exp(4'b0111, 4'b0110, 4'b0001, 4, 5, 6, 0, 8'h20));
        send(4'b0111, FU_LSU, FU_BR, FU_MUL, FU_DIV, 8'h20);
        send(4'b0000, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h28);
        repeat (3) tick();

        // ROB wrap: tail 62 -> indices 62,63,0, next bundle starts at 1.
        do_recover(6'd62, 7'd10);
        exp_q.push_back(mk_exp(4'b0111, 4'b0111, 4'b0000, 62, 63, 0, 0, 8'h30));
        send(4'b0111, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h30);
        exp_q.push_back(mk_exp(4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0, 8'h33));
        send(4'b0001, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h33);
        repeat (3) tick();

        // ROB stall at count 62; retiring 2 releases the bundle one cycle later.
        do_recover(6'd10, 7'd62);
        send(4'b1111, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h40);
        for (int k = 0; k < 3; k++) begin
            check("rob_stall_ready", 64'(ready), 64'd0);
            tick();
        end
        exp_q.push_back(mk_exp(4'b1111, 4'b1111, 4'b0000, 10, 11, 12, 13, 8'h40));
        rob_retire_count = 3'd2;
        tick();
        rob_retire_count = '0;
        check("rob_release_ready", 64'(ready), 64'd1);
        repeat (3) tick();

        // Memory credit stall: 15 LSU uops leave one credit, a 2-LSU bundle waits.
        do_recover(6'd0, 7'd0);
        exp_q.push_back(mk_exp(4'b1111, 4'b0000, 4'b1111, 0, 1, 2, 3, 8'h50));
        exp_q.push_back(mk_exp(4'b1111, 4'b0000, 4'b1111, 4, 5, 6, 7, 8'h54));
        exp_q.push_back(mk_exp(4'b1111, 4'b0000, 4'b1111, 8, 9, 10, 11, 8'h58));
        exp_q.push_back(mk_exp(4'b0111, 4'b0000, 4'b0111, 12, 13, 14, 0, 8'h5c));
        send(4'b1111, FU_LSU, FU_LSU, FU_LSU, FU_LSU, 8'h50);
        send(4'b1111, FU_LSU, FU_LSU, FU_LSU, FU_LSU, 8'h54);
        send(4'b1111, FU_LSU, FU_LSU, FU_LSU, FU_LSU, 8'h58);
        send(4'b0111, FU_LSU, FU_LSU, FU_LSU, FU_LSU, 8'h5c);
        send(4'b0011, FU_LSU, FU_LSU, FU_ALU, FU_ALU, 8'h60);
        for (int k = 0; k < 2; k++) begin
            check("mem_stall_ready", 64'(ready), 64'd0);
            tick();
        end
        exp_q.push_back(mk_exp(4'b0011, 4'b0000, 4'b0011, 15, 16, 0, 0, 8'h60));
        iq_mem_issue_count = 3'd1;
        tick();
        iq_mem_issue_count = '0;
        check("mem_release_ready", 64'(ready), 64'd1);
        repeat (3) tick();

        // Recover while a stalled bundle is held: it is dropped, credits refill.
        send(4'b0001, FU_LSU, FU_ALU, FU_ALU, FU_ALU, 8'h70);
        check("held_stall_ready", 64'(ready), 64'd0);
        tick();
        do_recover(6'd20, 7'd5);
        repeat (2) tick();
        exp_q.push_back(mk_exp(4'b0011, 4'b0010, 4'b0001, 20, 21, 0, 0, 8'h71));
        send(4'b0011, FU_LSU, FU_ALU, FU_ALU, FU_ALU, 8'h71);
        repeat (3) tick();

        // Mid-operation reset while outputs are valid and a second bundle is held.
        exp_q.push_back(mk_exp(4'b0001, 4'b0001, 4'b0000, 22, 0, 0, 0, 8'h80));
        send(4'b0001, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h80);
        send(4'b0001, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h81);
        #6;
        reset = 1'b0;
        #1;
        check("async_reset_alloc", 64'(rob_alloc_valid), 64'd0);
        check("async_reset_int", 64'(iq_int_valid), 64'd0);
        check("async_reset_uop_out_zero", 64'(uop_out != '0), 64'd0);
        check("async_reset_ready", 64'(ready), 64'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        exp_q.push_back(mk_exp(4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 8'h90));
        send(4'b0001, FU_ALU, FU_ALU, FU_ALU, FU_ALU, 8'h90);
        repeat (4) tick();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
